dpu_pio_arbiter: RTL and testbench

Two-master arbiter between the DPU PIO command port of `dpu_top` and its two sources. Port A is the host CSR/PIO path. Port B is the AXI-Stream DMA bridge. The block grants one byte command at a time, registers it onto the single downstream PIO port, and holds off both masters while a read is outstanding. It routes each read response back to the master that issued it, and times out lost responses.

---
 rtl/dpu_pio_arbiter.sv | 155 +++++++++++++++
 tb/tb_dpu_pio_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpu_pio_arbiter.sv
// dpu_pio_arbiter: two-master arbiter in front of the DPU PIO command port.
// One command in flight at a time; read responses return to their issuer.
module dpu_pio_arbiter #(
    parameter int ADDR_BITS   = 24,
    parameter int RSP_TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_cmd_valid,
    output logic                 a_cmd_ready,
    input  logic [2:0]           a_cmd_type,
    input  logic [ADDR_BITS-1:0] a_cmd_addr,
    input  logic [7:0]           a_cmd_data,
    output logic                 a_rsp_valid,
    output logic [7:0]           a_rsp_data,
    input  logic                 b_cmd_valid,
    output logic                 b_cmd_ready,
    input  logic [2:0]           b_cmd_type,
    input  logic [ADDR_BITS-1:0] b_cmd_addr,
    input  logic [7:0]           b_cmd_data,
    output logic                 b_rsp_valid,
    output logic [7:0]           b_rsp_data,
    input  logic                 b_lock,
    output logic                 m_cmd_valid,
    input  logic                 m_cmd_ready,
    output logic [2:0]           m_cmd_type,
    output logic [ADDR_BITS-1:0] m_cmd_addr,
    output logic [7:0]           m_cmd_data,
    input  logic                 m_rsp_valid,
    input  logic [7:0]           m_rsp_data,
    output logic                 owner,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_stray,
    input  logic                 err_clr
);

    localparam int CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);
    localparam logic [2:0] T_READ = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FWD,
        S_RSP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_cnt;
    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_rsp_hit;
    logic             w_timeout;
    logic             w_stray;
    logic [7:0]       w_rsp_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        w_rsp_hit = 1'b0;
        w_timeout = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // A tie goes to whichever master did not win last time
                if (b_lock) begin
                    w_grant_b = b_cmd_valid;
                end else if (a_cmd_valid && b_cmd_valid) begin
                    w_grant_a = r_last_grant;
                    w_grant_b = ~r_last_grant;
                end else begin
                    w_grant_a = a_cmd_valid;
                    w_grant_b = b_cmd_valid;
                end
                if (w_grant_a || w_grant_b) begin
                    w_next = S_FWD;
                end
            end
            S_FWD: begin
                if (m_cmd_ready) begin
                    w_next = (m_cmd_type == T_READ) ? S_RSP : S_IDLE;
                end
            end
            S_RSP: begin
                w_rsp_hit = m_rsp_valid;
                w_timeout = ~m_rsp_valid && (r_cnt == CNT_LAST);
                if (w_rsp_hit || w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign a_cmd_ready = w_grant_a;
    assign b_cmd_ready = w_grant_b;
    assign busy        = (r_state != S_IDLE);
    assign w_stray     = m_rsp_valid && (r_state != S_RSP);
    assign w_rsp_data  = w_rsp_hit ? m_rsp_data : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cmd_valid  <= 1'b0;
            m_cmd_type   <= '0;
            m_cmd_addr   <= '0;
            m_cmd_data   <= '0;
            owner        <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            a_rsp_valid  <= 1'b0;
            a_rsp_data   <= '0;
            b_rsp_valid  <= 1'b0;
            b_rsp_data   <= '0;
            err_timeout  <= 1'b0;
            err_stray    <= 1'b0;
        end else begin
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            if (w_grant_a || w_grant_b) begin
                m_cmd_valid  <= 1'b1;
                m_cmd_type   <= w_grant_b ? b_cmd_type : a_cmd_type;
                m_cmd_addr   <= w_grant_b ? b_cmd_addr : a_cmd_addr;
                m_cmd_data   <= w_grant_b ? b_cmd_data : a_cmd_data;
                owner        <= w_grant_b;
                r_last_grant <= w_grant_b;
            end else if (r_state == S_FWD && m_cmd_ready) begin
                m_cmd_valid <= 1'b0;
            end
            r_cnt <= (r_state == S_RSP) ? r_cnt + 1'b1 : '0;
            if (w_rsp_hit || w_timeout) begin
                if (owner) begin
                    b_rsp_valid <= 1'b1;
                    b_rsp_data  <= w_rsp_data;
                end else begin
                    a_rsp_valid <= 1'b1;
                    a_rsp_data  <= w_rsp_data;
                end
            end
            // A new error event in the same cycle as err_clr stays set
            err_timeout <= w_timeout | (err_timeout & ~err_clr);
            err_stray   <= w_stray | (err_stray & ~err_clr);
        end
    end

endmodule

// File: tb/tb_dpu_pio_arbiter.sv
// tb_dpu_pio_arbiter: randomized scoreboard bench for dpu_pio_arbiter.
// A transaction-level model predicts grants, forwarded commands and responses.
`timescale 1ns/1ps
module tb_dpu_pio_arbiter;

    localparam int AW  = 24;
    localparam int TMO = 8;

    localparam int P_IDLE = 0;
    localparam int P_FWD  = 1;
    localparam int P_WAIT = 2;

    typedef struct packed {
        logic [2:0]    t;
        logic [AW-1:0] a;
        logic [7:0]    d;
    } cmd_t;

    typedef struct packed {
        logic own;
        cmd_t c;
    } fwd_t;

    typedef struct packed {
        logic [31:0] due;
        logic [7:0]  d;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_cmd_valid = 1'b0;
    logic          a_cmd_ready;
    logic [2:0]    a_cmd_type = '0;
    logic [AW-1:0] a_cmd_addr = '0;
    logic [7:0]    a_cmd_data = '0;
    logic          a_rsp_valid;
    logic [7:0]    a_rsp_data;
    logic          b_cmd_valid = 1'b0;
    logic          b_cmd_ready;
    logic [2:0]    b_cmd_type = '0;
    logic [AW-1:0] b_cmd_addr = '0;
    logic [7:0]    b_cmd_data = '0;
    logic          b_rsp_valid;
    logic [7:0]    b_rsp_data;
    logic          b_lock = 1'b0;
    logic          m_cmd_valid;
    logic          m_cmd_ready = 1'b1;
    logic [2:0]    m_cmd_type;
    logic [AW-1:0] m_cmd_addr;
    logic [7:0]    m_cmd_data;
    logic          m_rsp_valid = 1'b0;
    logic [7:0]    m_rsp_data = '0;
    logic          owner;
    logic          busy;
    logic          err_timeout;
    logic          err_stray;
    logic          err_clr = 1'b0;

    dpu_pio_arbiter #(
        .ADDR_BITS  (AW),
        .RSP_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_cmd_valid(a_cmd_valid),
        .a_cmd_ready(a_cmd_ready),
        .a_cmd_type (a_cmd_type),
        .a_cmd_addr (a_cmd_addr),
        .a_cmd_data (a_cmd_data),
        .a_rsp_valid(a_rsp_valid),
        .a_rsp_data (a_rsp_data),
        .b_cmd_valid(b_cmd_valid),
        .b_cmd_ready(b_cmd_ready),
        .b_cmd_type (b_cmd_type),
        .b_cmd_addr (b_cmd_addr),
        .b_cmd_data (b_cmd_data),
        .b_rsp_valid(b_rsp_valid),
        .b_rsp_data (b_rsp_data),
        .b_lock     (b_lock),
        .m_cmd_valid(m_cmd_valid),
        .m_cmd_ready(m_cmd_ready),
        .m_cmd_type (m_cmd_type),
        .m_cmd_addr (m_cmd_addr),
        .m_cmd_data (m_cmd_data),
        .m_rsp_valid(m_rsp_valid),
        .m_rsp_data (m_rsp_data),
        .owner      (owner),
        .busy       (busy),
        .err_timeout(err_timeout),
        .err_stray  (err_stray),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    cmd_t qa[$];
    cmd_t qb[$];
    fwd_t exp_cmd[$];
    rsp_t exp_ra[$];
    rsp_t exp_rb[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cyc = 0;

    // Abstract model of the arbiter's transaction progress
    int       ph = P_IDLE;
    logic     m_last = 1'b1;
    logic     m_own = 1'b0;
    logic [2:0] m_type = '0;
    int       wcnt = 0;
    logic     m_et = 1'b0;
    logic     m_es = 1'b0;

    logic acc_a = 1'b0;
    logic acc_b = 1'b0;
    logic rd_hs = 1'b0;

    int         go_pct = 100;
    int         rdy_pct = 100;
    int         lock_mode = 0;
    int         rsp_fix = -1;
    bit         rsp_never = 1'b0;
    bit         rnd_misc = 1'b0;
    bit         stray_req = 1'b0;
    bit         clr_req = 1'b0;
    bit         rsp_pend = 1'b0;
    int         rsp_cnt = 0;
    bit         use_dat_fix = 1'b0;
    logic [7:0] rsp_dat_fix = '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    initial begin : mon
        logic ea;
        logic eb;
        logic stray;
        fwd_t f;
        rsp_t r;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                ph = P_IDLE;
                m_last = 1'b1;
                m_own = 1'b0;
                m_type = '0;
                wcnt = 0;
                m_et = 1'b0;
                m_es = 1'b0;
                exp_cmd.delete();
                exp_ra.delete();
                exp_rb.delete();
                acc_a = 1'b0;
                acc_b = 1'b0;
                rd_hs = 1'b0;
            end else begin
                ea = 1'b0;
                eb = 1'b0;
                if (ph == P_IDLE) begin
                    if (b_lock) begin
                        eb = b_cmd_valid;
                    end else if (a_cmd_valid && b_cmd_valid) begin
                        ea = m_last;
                        eb = ~m_last;
                    end else begin
                        ea = a_cmd_valid;
                        eb = b_cmd_valid;
                    end
                end
                chk("a_cmd_ready", a_cmd_ready, ea);
                chk("b_cmd_ready", b_cmd_ready, eb);
                chk("busy", busy, ph != P_IDLE);
                chk("m_cmd_valid", m_cmd_valid, ph == P_FWD);
                chk("owner", owner, m_own);
                chk("err_timeout", err_timeout, m_et);
                chk("err_stray", err_stray, m_es);

                if (m_cmd_valid && m_cmd_ready) begin
                    chk("m_cmd_expected", exp_cmd.size() != 0, 1);
                    if (exp_cmd.size() != 0) begin
                        f = exp_cmd.pop_front();
                        chk("m_cmd_type", m_cmd_type, f.c.t);
                        chk("m_cmd_addr", m_cmd_addr, f.c.a);
                        chk("m_cmd_data", m_cmd_data, f.c.d);
                        chk("m_cmd_owner", owner, f.own);
                    end
                end

                if (exp_ra.size() != 0 && exp_ra[0].due == cyc) begin
                    r = exp_ra.pop_front();
                    chk("a_rsp_valid", a_rsp_valid, 1);
                    chk("a_rsp_data", a_rsp_data, r.d);
                end else begin
                    chk("a_rsp_valid", a_rsp_valid, 0);
                end
                if (exp_rb.size() != 0 && exp_rb[0].due == cyc) begin
                    r = exp_rb.pop_front();
                    chk("b_rsp_valid", b_rsp_valid, 1);
                    chk("b_rsp_data", b_rsp_data, r.d);
                end else begin
                    chk("b_rsp_valid", b_rsp_valid, 0);
                end

                acc_a = a_cmd_valid && a_cmd_ready;
                acc_b = b_cmd_valid && b_cmd_ready;
                rd_hs = m_cmd_valid && m_cmd_ready && (m_cmd_type == 3'd2);

                stray = m_rsp_valid && (ph != P_WAIT);
                if (err_clr) begin
                    m_et = 1'b0;
                    m_es = 1'b0;
                end
                if (stray) m_es = 1'b1;

                case (ph)
                    P_IDLE: begin
                        if (ea || eb) begin
                            f.own = eb;
                            f.c = eb ? cmd_t'({b_cmd_type, b_cmd_addr, b_cmd_data})
                                     : cmd_t'({a_cmd_type, a_cmd_addr, a_cmd_data});
                            exp_cmd.push_back(f);
                            m_own = eb;
                            m_last = eb;
                            m_type = f.c.t;
                            ph = P_FWD;
                        end
                    end
                    P_FWD: begin
                        if (m_cmd_ready) begin
                            ph = (m_type == 3'd2) ? P_WAIT : P_IDLE;
                            wcnt = 0;
                        end
                    end
                    default: begin
                        r.due = cyc + 1;
                        if (m_rsp_valid || wcnt == TMO - 1) begin
                            r.d = m_rsp_valid ? m_rsp_data : 8'h00;
                            if (!m_rsp_valid) m_et = 1'b1;
                            if (m_own) exp_rb.push_back(r);
                            else exp_ra.push_back(r);
                            ph = P_IDLE;
                        end else begin
                            wcnt++;
                        end
                    end
                endcase
            end
        end
    end

    task automatic step();
        cmd_t c;
        @(posedge clk);
        #1;
        if (acc_a) a_cmd_valid = 1'b0;
        if (acc_b) b_cmd_valid = 1'b0;
        if (!a_cmd_valid && qa.size() != 0 && int'($urandom_range(99)) < go_pct) begin
            c = qa.pop_front();
            a_cmd_valid = 1'b1;
            a_cmd_type = c.t;
            a_cmd_addr = c.a;
            a_cmd_data = c.d;
        end
        if (!b_cmd_valid && qb.size() != 0 && int'($urandom_range(99)) < go_pct) begin
            c = qb.pop_front();
            b_cmd_valid = 1'b1;
            b_cmd_type = c.t;
            b_cmd_addr = c.a;
            b_cmd_data = c.d;
        end
        m_cmd_ready = int'($urandom_range(99)) < rdy_pct;
        if (lock_mode == 2 && $urandom_range(7) == 0) b_lock = ~b_lock;
        err_clr = clr_req || (rnd_misc && $urandom_range(15) == 0);
        clr_req = 1'b0;
        m_rsp_valid = 1'b0;
        if (rd_hs && !rsp_never) begin
            rsp_pend = 1'b1;
            rsp_cnt = (rsp_fix >= 0) ? rsp_fix : int'($urandom_range(9));
        end
        if (rsp_pend) begin
            if (rsp_cnt == 0) begin
                m_rsp_valid = 1'b1;
                m_rsp_data = use_dat_fix ? rsp_dat_fix : 8'($urandom);
                rsp_pend = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end
        if (stray_req || (rnd_misc && !rsp_pend && !m_rsp_valid
                          && $urandom_range(39) == 0)) begin
            m_rsp_valid = 1'b1;
            m_rsp_data = 8'($urandom);
        end
        stray_req = 1'b0;
    endtask

    task automatic drain(int maxc);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || a_cmd_valid || b_cmd_valid
                || ph != P_IDLE || rsp_pend) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_in_budget", n < maxc, 1);
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_cmd_valid = 1'b0;
        b_cmd_valid = 1'b0;
        m_rsp_valid = 1'b0;
        err_clr = 1'b0;
        rsp_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic cmd_t mk(logic [2:0] t, logic [AW-1:0] a, logic [7:0] d);
        cmd_t c;
        c.t = t;
        c.a = a;
        c.d = d;
        return c;
    endfunction

    initial begin : main
        int n;
        logic [2:0] t;
        do_reset();
        chk("rst_m_cmd_type", m_cmd_type, 0);
        chk("rst_m_cmd_addr", m_cmd_addr, 0);
        chk("rst_m_cmd_data", m_cmd_data, 0);
        chk("rst_a_rsp_data", a_rsp_data, 0);
        chk("rst_b_rsp_data", b_rsp_data, 0);

        // Single write from A
        qa.push_back(mk(3'd0, 24'h000010, 8'h5A));
        drain(50);

        // Continuous contention: A first after reset, then alternation
        do_reset();
        for (int i = 0; i < 4; i++) begin
            qa.push_back(mk(3'd0, AW'(24'h100 + i), 8'(8'hA0 + i)));
            qb.push_back(mk(3'd5, AW'(24'h200 + i), 8'(8'hB0 + i)));
        end
        drain(100);

        // DMA lock keeps A out until released
        b_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            qa.push_back(mk(3'd6, AW'(24'h300 + i), 8'(i)));
            qb.push_back(mk(3'd0, AW'(24'h400 + i), 8'(i)));
        end
        repeat (12) step();
        b_lock = 1'b0;
        drain(100);

        // B read answered after a fixed delay, B re-asserting valid
        rsp_fix = 3;
        use_dat_fix = 1'b1;
        rsp_dat_fix = 8'hC3;
        qb.push_back(mk(3'd2, 24'h000100, 8'h00));
        qb.push_back(mk(3'd0, 24'h000101, 8'h11));
        drain(100);

        // A read with no response: timeout, clear, then stray
        rsp_never = 1'b1;
        qa.push_back(mk(3'd2, 24'h000020, 8'h00));
        drain(100);
        chk("timeout_flag_set", err_timeout, 1);
        clr_req = 1'b1;
        repeat (2) step();
        chk("timeout_flag_clr", err_timeout, 0);
        stray_req = 1'b1;
        repeat (2) step();
        chk("stray_flag_set", err_stray, 1);
        chk("stray_no_timeout", err_timeout, 0);

        // Randomized traffic
        rsp_never = 1'b0;
        rsp_fix = -1;
        use_dat_fix = 1'b0;
        rnd_misc = 1'b1;
        lock_mode = 2;
        go_pct = 70;
        rdy_pct = 75;
        for (int i = 0; i < 150; i++) begin
            t = ($urandom_range(2) == 0) ? 3'd2 : 3'($urandom_range(7));
            qa.push_back(mk(t, AW'($urandom), 8'($urandom)));
            t = ($urandom_range(2) == 0) ? 3'd2 : 3'($urandom_range(7));
            qb.push_back(mk(t, AW'($urandom), 8'($urandom)));
        end
        drain(20000);
        lock_mode = 0;
        b_lock = 1'b0;
        rnd_misc = 1'b0;
        go_pct = 100;
        rdy_pct = 100;
        repeat (3) step();
        chk("exp_cmd_left", exp_cmd.size(), 0);
        chk("exp_ra_left", exp_ra.size(), 0);
        chk("exp_rb_left", exp_rb.size(), 0);

        // Reset while a read is outstanding
        rsp_never = 1'b1;
        clr_req = 1'b1;
        qa.push_back(mk(3'd2, 24'h000200, 8'h00));
        n = 0;
        while (!(busy && !m_cmd_valid) && n < 50) begin
            step();
            n++;
        end
        chk("reached_rsp_wait", n < 50, 1);
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_m_cmd_valid", m_cmd_valid, 0);
        chk("arst_m_cmd_type", m_cmd_type, 0);
        chk("arst_m_cmd_addr", m_cmd_addr, 0);
        chk("arst_m_cmd_data", m_cmd_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_owner", owner, 0);
        chk("arst_a_rsp_valid", a_rsp_valid, 0);
        chk("arst_a_rsp_data", a_rsp_data, 0);
        chk("arst_b_rsp_data", b_rsp_data, 0);
        chk("arst_err_timeout", err_timeout, 0);
        chk("arst_err_stray", err_stray, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stray_req = 1'b1;
        repeat (2) step();
        chk("late_rsp_stray", err_stray, 1);
        chk("late_rsp_no_timeout", err_timeout, 0);
        chk("late_rsp_a_valid", a_rsp_valid, 0);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
